fft_bfly_stage: RTL and testbench
=================================

FFT_BFLY_STAGE -- requirements
Module: fft_bfly_stage

Interface
REQ-001 Parameter HALF, default 32, meaning butterfly pairs per frame (delay-line span; power of two, >=2).
REQ-002 Parameter SCALE, default 0, meaning extra arithmetic right shift (0 or 1) applied to both outputs for per-stage overflow control.
REQ-003 Port clk  input  1  meaning sole clock, rising-edge.
REQ-004 Port nrst  input  1  meaning reset, asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  meaning in_a/in_b hold a valid butterfly pair this cycle.
REQ-006 Port in_a  input  32  meaning upper-input sample x[n]: [31:16] real, [15:0] imag, signed Q1.15.
REQ-007 Port in_b  input  32  meaning lower-input sample x[n+HALF], same format.
REQ-008 Port tw_addr  output  $clog2(HALF)  meaning twiddle ROM index, combinational from the pair counter.
REQ-009 Port tw_data  input  32  meaning twiddle W^k from an external synchronous ROM with 1-cycle read latency, [31:16] cos, [15:0] -sin, signed Q1.15.
REQ-010 Port out_valid  output  1  meaning out_sum/out_diff valid this cycle.
REQ-011 Port out_sum  output  32  meaning (a+b)>>>SCALE, packed as the inputs.
REQ-012 Port out_diff  output  32  meaning ((a-b)*W)>>>SCALE, packed as the inputs.
REQ-013 Port frame_last  output  1  meaning qualifies out_valid for pair index HALF-1.

Function
REQ-014 Pair counter k (0..HALF-1) SHALL increment on each cycle with in_valid=1, wrap HALF-1 -> 0, and hold otherwise; tw_addr SHALL equal k.
REQ-015 Pipeline SHALL have 3 register stages; a pair accepted at rising edge T SHALL appear on the outputs with out_valid=1 after edge T+3.
REQ-016 Stage 1 SHALL register sum and diff of real and imag parts at 17-bit width with sign extension and no overflow.
REQ-017 Stage 2 SHALL multiply the diff by tw_data sampled at edge T+1. The four 17x16 signed products SHALL be held at full 33-bit precision.
REQ-018 Stage 3 SHALL form re = dr*wr - di*wi and im = dr*wi + di*wr at 34 bits, then arithmetic-shift right by 15+SCALE (floor, no rounding).
REQ-019 Stage 3 SHALL arithmetic-shift sum parts right by SCALE.
REQ-020 All four output parts SHALL saturate to [-32768, 32767].
REQ-021 in_valid=0 cycles SHALL propagate as bubbles, with out_valid=0 exactly 3 edges later. Data outputs SHALL hold their last valid value during bubbles.
REQ-022 No backpressure: every accepted pair SHALL produce exactly one output, in order.
REQ-023 frame_last SHALL be 1 only with out_valid=1 for the pair that was accepted with k=HALF-1.
REQ-024 Back-to-back frames SHALL need no idle cycle; k wraps seamlessly.

Reset
REQ-025 nrst=0 SHALL asynchronously clear k, all stage valids, out_valid, frame_last, out_sum and out_diff to 0.
REQ-026 Reset asserted mid-frame SHALL discard all in-flight pairs (no output after release). The next accepted pair SHALL be k=0.
REQ-027 The first pair accepted at the first rising edge after nrst deasserts SHALL be processed normally.

Verification
REQ-028 Reset mid-stream with pairs in flight -> out_valid=0, outputs 0x00000000 immediately (before a clock edge). After release, the first pair uses tw_addr=0.
REQ-029 SCALE=0, a=(100,50), b=(20,10), tw=(0x7FFF,0x0000) -> 3 edges later out_sum=(120,60), out_diff=(79,39).
REQ-030 SCALE=0, a=(300,-200), b=(100,100), tw=(0x0000,0x8000) (-j) -> out_sum=(400,-100), out_diff=(-300,-200).
REQ-031 SCALE=0, a=b=(32767,-32768), tw=(0x7FFF,0) -> out_sum=(32767,-32768) saturated, out_diff=(0,0).
REQ-032 SCALE=1, a=b=(32767,32767) -> out_sum=(32767,32767) with no saturation.
REQ-033 Stream 2*HALF pairs with random in_valid gaps -> tw_addr sequence 0..HALF-1 twice. Outputs match a bit-exact model in order. frame_last is asserted exactly twice, on the 32nd and 64th outputs.

Source files
------------

// File: rtl/fft_bfly_stage.sv
// Radix-2 DIF butterfly stage: sum/diff, twiddle multiply on the diff path,
// optional per-stage scaling and saturation, streaming with bubble support.
module fft_bfly_stage #(
  parameter int unsigned HALF  = 32,
  parameter int unsigned SCALE = 0
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    in_valid,
  input  logic [31:0]             in_a,
  input  logic [31:0]             in_b,
  output logic [$clog2(HALF)-1:0] tw_addr,
  input  logic [31:0]             tw_data,
  output logic                    out_valid,
  output logic [31:0]             out_sum,
  output logic [31:0]             out_diff,
  output logic                    frame_last
);

  localparam int unsigned AW  = $clog2(HALF);
  localparam int unsigned PSH = 15 + SCALE;
  localparam logic [AW-1:0] KLAST = AW'(HALF - 1);

  function automatic logic [15:0] sat16(input logic signed [33:0] x);
    if (x > 34'sd32767)
      return 16'h7fff;
    else if (x < -34'sd32768)
      return 16'h8000;
    else
      return x[15:0];
  endfunction

  logic [AW-1:0] k_q, k_d;

  logic               v1_q, v1_d, l1_q, l1_d;
  logic signed [16:0] sr1_q, sr1_d, si1_q, si1_d;
  logic signed [16:0] dr1_q, dr1_d, di1_q, di1_d;

  logic               v2_q, v2_d, l2_q, l2_d;
  logic signed [16:0] sr2_q, sr2_d, si2_q, si2_d;
  logic signed [32:0] prr_q, prr_d, pii_q, pii_d;
  logic signed [32:0] pri_q, pri_d, pir_q, pir_d;

  logic               v3_q, v3_d, l3_q, l3_d;
  logic signed [16:0] sr3_q, sr3_d, si3_q, si3_d;
  logic signed [33:0] re3_q, re3_d, im3_q, im3_d;

  logic               ov_q, ov_d, fl_q, fl_d;
  logic [31:0]        os_q, os_d, od_q, od_d;

  logic signed [15:0] a_re, a_im, b_re, b_im;
  logic signed [15:0] w_re, w_im;
  logic signed [33:0] re_w, im_w;
  logic signed [33:0] sre_w, sim_w;

  always_comb begin
    k_d = k_q;
    if (in_valid)
      k_d = k_q + AW'(1);
  end

  // stage 1: widened sum and difference, cannot overflow at 17 bits
  always_comb begin
    a_re  = $signed(in_a[31:16]);
    a_im  = $signed(in_a[15:0]);
    b_re  = $signed(in_b[31:16]);
    b_im  = $signed(in_b[15:0]);
    v1_d  = in_valid;
    l1_d  = in_valid && (k_q == KLAST);
    sr1_d = 17'(a_re) + 17'(b_re);
    si1_d = 17'(a_im) + 17'(b_im);
    dr1_d = 17'(a_re) - 17'(b_re);
    di1_d = 17'(a_im) - 17'(b_im);
  end

  // stage 2: ROM word for this pair arrives one cycle after acceptance
  always_comb begin
    w_re  = $signed(tw_data[31:16]);
    w_im  = $signed(tw_data[15:0]);
    v2_d  = v1_q;
    l2_d  = l1_q;
    sr2_d = sr1_q;
    si2_d = si1_q;
    prr_d = 33'(dr1_q) * 33'(w_re);
    pii_d = 33'(di1_q) * 33'(w_im);
    pri_d = 33'(dr1_q) * 33'(w_im);
    pir_d = 33'(di1_q) * 33'(w_re);
  end

  always_comb begin
    re_w  = 34'(prr_q) - 34'(pii_q);
    im_w  = 34'(pri_q) + 34'(pir_q);
    v3_d  = v2_q;
    l3_d  = l2_q;
    sr3_d = sr2_q >>> SCALE;
    si3_d = si2_q >>> SCALE;
    re3_d = re_w >>> PSH;
    im3_d = im_w >>> PSH;
  end

  // output register holds the last result across bubbles
  always_comb begin
    sre_w = 34'(sr3_q);
    sim_w = 34'(si3_q);
    ov_d  = v3_q;
    fl_d  = v3_q && l3_q;
    os_d  = os_q;
    od_d  = od_q;
    if (v3_q) begin
      os_d = {sat16(sre_w), sat16(sim_w)};
      od_d = {sat16(re3_q), sat16(im3_q)};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      k_q   <= '0;
      v1_q  <= 1'b0;
      l1_q  <= 1'b0;
      sr1_q <= '0;
      si1_q <= '0;
      dr1_q <= '0;
      di1_q <= '0;
      v2_q  <= 1'b0;
      l2_q  <= 1'b0;
      sr2_q <= '0;
      si2_q <= '0;
      prr_q <= '0;
      pii_q <= '0;
      pri_q <= '0;
      pir_q <= '0;
      v3_q  <= 1'b0;
      l3_q  <= 1'b0;
      sr3_q <= '0;
      si3_q <= '0;
      re3_q <= '0;
      im3_q <= '0;
      ov_q  <= 1'b0;
      fl_q  <= 1'b0;
      os_q  <= '0;
      od_q  <= '0;
    end else begin
      k_q   <= k_d;
      v1_q  <= v1_d;
      l1_q  <= l1_d;
      sr1_q <= sr1_d;
      si1_q <= si1_d;
      dr1_q <= dr1_d;
      di1_q <= di1_d;
      v2_q  <= v2_d;
      l2_q  <= l2_d;
      sr2_q <= sr2_d;
      si2_q <= si2_d;
      prr_q <= prr_d;
      pii_q <= pii_d;
      pri_q <= pri_d;
      pir_q <= pir_d;
      v3_q  <= v3_d;
      l3_q  <= l3_d;
      sr3_q <= sr3_d;
      si3_q <= si3_d;
      re3_q <= re3_d;
      im3_q <= im3_d;
      ov_q  <= ov_d;
      fl_q  <= fl_d;
      os_q  <= os_d;
      od_q  <= od_d;
    end
  end

  assign tw_addr    = k_q;
  assign out_valid  = ov_q;
  assign frame_last = fl_q;
  assign out_sum    = os_q;
  assign out_diff   = od_q;

endmodule

// File: tb/tb_fft_bfly_stage.sv
// Bench for fft_bfly_stage: SCALE=0 and SCALE=1 instances against an
// arithmetic reference model, with directed literal cases and a random stream.
module tb_fft_bfly_stage;

  localparam int HALF = 32;
  localparam int AW   = $clog2(HALF);

  logic          clk = 0;
  logic          nrst = 0;
  logic          in_valid = 0;
  logic [31:0]   in_a = 0, in_b = 0;
  logic [31:0]   tw_data = 0;
  logic [AW-1:0] tw_addr0, tw_addr1;
  logic          ov0, ov1, fl0, fl1;
  logic [31:0]   os0, os1, od0, od1;

  always #5 clk = ~clk;

  fft_bfly_stage #(.HALF(HALF), .SCALE(0)) u0 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .tw_addr(tw_addr0),
    .tw_data(tw_data), .out_valid(ov0), .out_sum(os0),
    .out_diff(od0), .frame_last(fl0));

  fft_bfly_stage #(.HALF(HALF), .SCALE(1)) u1 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .tw_addr(tw_addr1),
    .tw_data(tw_data), .out_valid(ov1), .out_sum(os1),
    .out_diff(od1), .frame_last(fl1));

  logic [31:0] rom [HALF];
  always @(posedge clk) tw_data <= rom[tw_addr0];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic longint sat(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // floor division by 2^n on a signed value
  function automatic longint fdiv(input longint x, input int n);
    longint d;
    d = longint'(1) << n;
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic logic [63:0] bfly(input logic [31:0] a, b, w,
                                       input int sc);
    longint ar, ai, br, bi, wr, wi, dr, di;
    logic [15:0] r0, r1, r2, r3;
    ar = $signed(a[31:16]); ai = $signed(a[15:0]);
    br = $signed(b[31:16]); bi = $signed(b[15:0]);
    wr = $signed(w[31:16]); wi = $signed(w[15:0]);
    dr = ar - br; di = ai - bi;
    r0 = 16'(sat(fdiv(ar + br, sc)));
    r1 = 16'(sat(fdiv(ai + bi, sc)));
    r2 = 16'(sat(fdiv(dr * wr - di * wi, 15 + sc)));
    r3 = 16'(sat(fdiv(dr * wi + di * wr, 15 + sc)));
    return {r0, r1, r2, r3};
  endfunction

  typedef struct {
    int          due;
    logic [63:0] r0;
    logic [63:0] r1;
    logic        last;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          km = 0;
  int          addr_log[$];

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q.delete();
      km  = 0;
      cyc = 0;
    end else begin
      cyc++;
      if (in_valid) begin
        exp_t e;
        e.due  = cyc + 3;
        e.r0   = bfly(in_a, in_b, rom[km], 0);
        e.r1   = bfly(in_a, in_b, rom[km], 1);
        e.last = (km == HALF - 1);
        q.push_back(e);
        addr_log.push_back(int'(tw_addr0));
        km = (km + 1) % HALF;
      end
    end
  end

  logic [31:0] ls0 = 0, ld0 = 0, ls1 = 0, ld1 = 0;
  bit          phase_on = 0;
  int          out_cnt = 0;
  int          fl_pos[$];

  always @(negedge clk) begin
    if (!nrst) begin
      chk("rst_valid", {ov0, ov1, fl0, fl1}, 4'b0);
      chk("rst_data", {os0, od0, os1, od1}, 128'b0);
      ls0 = 0; ld0 = 0; ls1 = 0; ld1 = 0;
    end else begin
      chk("tw_addr0", 64'(tw_addr0), 64'(km));
      chk("tw_addr1", 64'(tw_addr1), 64'(km));
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("out_valid", {ov0, ov1}, 2'b11);
        chk("frame_last", {fl0, fl1}, {e.last, e.last});
        chk("s0_sum", os0, e.r0[63:32]);
        chk("s0_diff", od0, e.r0[31:0]);
        chk("s1_sum", os1, e.r1[63:32]);
        chk("s1_diff", od1, e.r1[31:0]);
        ls0 = e.r0[63:32]; ld0 = e.r0[31:0];
        ls1 = e.r1[63:32]; ld1 = e.r1[31:0];
        if (phase_on) begin
          out_cnt++;
          if (fl0) fl_pos.push_back(out_cnt);
        end
      end else begin
        chk("bubble_valid", {ov0, ov1, fl0, fl1}, 4'b0);
        chk("bubble_hold", {os0, od0, os1, od1}, {ls0, ld0, ls1, ld1});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0;
    #2 nrst = 0;
    #1;
    chk("rst_now_valid", {ov0, ov1, fl0, fl1}, 4'b0);
    chk("rst_now_data", {os0, od0}, 64'b0);
    chk("rst_now_addr", 64'(tw_addr0), 64'(0));
    repeat (2) @(negedge clk);
    #2 nrst = 1;
  endtask

  task automatic send(input logic [31:0] a, b);
    @(negedge clk);
    in_valid = 1;
    in_a = a;
    in_b = b;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic directed(input string nm, input logic [31:0] a, b, w,
                          input bit use1, input logic [31:0] es, ed);
    do_reset();
    rom[0] = w;
    send(a, b);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk({nm, "_valid"}, use1 ? ov1 : ov0, 1'b1);
    chk({nm, "_sum"}, use1 ? os1 : os0, es);
    chk({nm, "_diff"}, use1 ? od1 : od0, ed);
    idle(3);
  endtask

  function automatic logic [31:0] pk(input int re, im);
    return {16'(re), 16'(im)};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < HALF; i++) rom[i] = $urandom;
    repeat (2) @(negedge clk);
    chk("init_reset", {ov0, os0, od0, 64'(tw_addr0)}, '0);
    #2 nrst = 1;
    idle(2);

    directed("d029", pk(100, 50), pk(20, 10), 32'h7fff0000, 0,
             pk(120, 60), pk(79, 39));
    directed("d030", pk(300, -200), pk(100, 100), 32'h00008000, 0,
             pk(400, -100), pk(-300, -200));
    directed("d031", pk(32767, -32768), pk(32767, -32768), 32'h7fff0000,
             0, pk(32767, -32768), pk(0, 0));
    directed("d032", pk(32767, 32767), pk(32767, 32767), 32'h7fff0000,
             1, pk(32767, 32767), pk(0, 0));

    for (int i = 0; i < HALF; i++) rom[i] = $urandom;

    // mid-stream reset with pairs in flight
    do_reset();
    for (int i = 0; i < 5; i++) send($urandom, $urandom);
    do_reset();
    idle(5);
    chk("post_rst_addr", 64'(tw_addr0), 64'(0));
    send(pk(1000, -1000), pk(-500, 250));
    idle(6);

    // two frames with random gaps
    do_reset();
    addr_log.delete();
    fl_pos.delete();
    out_cnt  = 0;
    phase_on = 1;
    for (int i = 0; i < 2 * HALF; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        a = pk(32767, -32768);
        b = pk(-32768, 32767);
      end
      send(a, b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(6);
    phase_on = 0;
    chk("stream_outs", 64'(out_cnt), 64'(2 * HALF));
    chk("addr_count", 64'(addr_log.size()), 64'(2 * HALF));
    for (int i = 0; i < addr_log.size(); i++)
      chk("addr_seq", 64'(addr_log[i]), 64'(i % HALF));
    chk("fl_count", 64'(fl_pos.size()), 64'(2));
    if (fl_pos.size() == 2) begin
      chk("fl_pos0", 64'(fl_pos[0]), 64'(HALF));
      chk("fl_pos1", 64'(fl_pos[1]), 64'(2 * HALF));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
